vector_lane_packer: RTL and testbench



---
 rtl/vec_pack_pkg.sv | 14 +
 rtl/vector_lane_packer.sv | 109 ++++++++++
 tb/tb_vector_lane_packer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_pack_pkg.sv
// Shared types for the serial-to-parallel lane packer.
// State encoding plus a helper for the lane-count width.
package vec_pack_pkg;

  typedef enum logic {
    VP_FILL = 1'b0,
    VP_FULL = 1'b1
  } vp_state_e;

  function automatic int vp_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_lane_packer.sv
// Packs a WIDTH-bit sample stream into NUM_LANE-wide vectors.
// Optional VEC_PACK_ZERO_PAD_EN: emit short frames zero-padded.
module vector_lane_packer
  import vec_pack_pkg::*;
#(
  parameter int NUM_LANE = 4,
  parameter int WIDTH    = 8,
  localparam int CW      = vp_cw(NUM_LANE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data [NUM_LANE],
  output logic [CW-1:0]    m_count,
  output logic             m_last,
  output logic             err_short
);

  localparam int IW = $clog2(NUM_LANE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LANE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_LANE);

  vp_state_e        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] lanes_q [NUM_LANE];
  logic [WIDTH-1:0] lanes_d [NUM_LANE];
  logic [CW-1:0]    count_q, count_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic          acc;
  logic          drain;
  logic [IW-1:0] wr;

  assign s_ready = ena & ((state_q == VP_FILL) | m_ready);
  assign acc     = s_valid & s_ready;
  assign drain   = (state_q == VP_FULL) & m_ready;
  // A sample taken while draining always starts a new vector.
  assign wr      = (state_q == VP_FULL) ? '0 : idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    count_d = count_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (drain) begin
      state_d = VP_FILL;
      count_d = '0;
      last_d  = 1'b0;
      for (int i = 0; i < NUM_LANE; i++) lanes_d[i] = '0;
    end
    if (acc) begin
      lanes_d[wr] = s_data;
      if (wr == LAST_IDX) begin
        state_d = VP_FULL;
        count_d = FULL_CNT;
        last_d  = s_last;
        idx_d   = '0;
      end else if (s_last) begin
`ifdef VEC_PACK_ZERO_PAD_EN
        state_d = VP_FULL;
        count_d = CW'(wr) + CW'(1);
        last_d  = 1'b1;
        idx_d   = '0;
`else
        for (int i = 0; i < NUM_LANE; i++) lanes_d[i] = '0;
        state_d = VP_FILL;
        idx_d   = '0;
        err_d   = 1'b1;
`endif
      end else begin
        idx_d = wr + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VP_FILL;
      idx_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LANE; i++) lanes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
      lanes_q <= lanes_d;
    end
  end

  assign m_valid   = (state_q == VP_FULL);
  assign m_data    = lanes_q;
  assign m_count   = count_q;
  assign m_last    = last_q;
  assign err_short = err_q;

endmodule

// File: tb/tb_vector_lane_packer.sv
// Directed self-checking bench for vector_lane_packer.
// Expectations follow VEC_PACK_ZERO_PAD_EN when defined.
module tb_vector_lane_packer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data [4];
  logic [2:0] m_count;
  logic       m_last;
  logic       err_short;

  int checks;
  int failures;

  vector_lane_packer #(
    .NUM_LANE(4),
    .WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_count(m_count),
    .m_last(m_last),
    .err_short(err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk();
    return {m_data[3], m_data[2], m_data[1], m_data[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; s_valid = 1'b0; s_data = '0;
    s_last = 1'b0; m_ready = 1'b0;
    #12;
    checks++;
    if (m_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++;
    if (pk() !== 32'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", pk()); end
    checks++;
    if (m_count !== 3'd0 || m_last !== 1'b0 || err_short !== 1'b0) begin
      failures++;
      $display("FAIL reset_misc got=%0d/%b/%b exp=0/0/0",
               m_count, m_last, err_short); end
    checks++;
    if (s_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready_ena1 got=%b exp=1", s_ready); end
    ena = 1'b0; #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready_ena0 got=%b exp=0", s_ready); end
    ena = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_vector();
    m_ready = 1'b1;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin failures++;
      $display("FAIL fv_early_valid got=%b exp=0", m_valid); end
    send(8'd40, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || pk() !== 32'h281E140A) begin failures++;
      $display("FAIL fv_vector got=%b/%h exp=1/281e140a", m_valid, pk()); end
    checks++;
    if (m_count !== 3'd4 || m_last !== 1'b1) begin failures++;
      $display("FAIL fv_count_last got=%0d/%b exp=4/1", m_count, m_last); end
    tick();
    checks++;
    if (m_valid !== 1'b0 || pk() !== 32'h0) begin failures++;
      $display("FAIL fv_drain got=%b/%h exp=0/0", m_valid, pk()); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      s_last  = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin failures++;
        $display("FAIL b2b_ready[%0d] got=%b exp=1", i, s_ready); end
      tick();
      if (i == 4) begin
        checks++;
        if (m_valid !== 1'b1 || pk() !== 32'h04030201 || m_last !== 1'b0)
        begin failures++;
          $display("FAIL b2b_vec0 got=%b/%h/%b exp=1/04030201/0",
                   m_valid, pk(), m_last); end
      end
      if (i == 5) begin
        checks++;
        if (m_valid !== 1'b0 || pk() !== 32'h00000005) begin failures++;
          $display("FAIL b2b_lane0 got=%b/%h exp=0/00000005",
                   m_valid, pk()); end
      end
      if (i == 8) begin
        checks++;
        if (m_valid !== 1'b1 || pk() !== 32'h08070605 || m_count !== 3'd4)
        begin failures++;
          $display("FAIL b2b_vec1 got=%b/%h/%0d exp=1/08070605/4",
                   m_valid, pk(), m_count); end
      end
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    s_valid = 1'b1; s_data = 8'd9; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || pk() !== 32'h04030201)
      begin failures++;
        $display("FAIL bp_hold[%0d] got=%b/%b/%h exp=0/1/04030201",
                 c, s_ready, m_valid, pk()); end
      tick();
    end
    m_ready = 1'b1; #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++;
      $display("FAIL bp_release_ready got=%b exp=1", s_ready); end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || pk() !== 32'h00000009) begin failures++;
      $display("FAIL bp_pending got=%b/%h exp=0/00000009", m_valid, pk()); end
    send(8'd10, 1'b0);
    send(8'd11, 1'b0);
    send(8'd12, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || pk() !== 32'h0C0B0A09 || m_last !== 1'b1) begin
      failures++;
      $display("FAIL bp_vec got=%b/%h/%b exp=1/0c0b0a09/1",
               m_valid, pk(), m_last); end
    tick();
  endtask

  task automatic test_short_frame();
    m_ready = 1'b1;
    send(8'hCE, 1'b0);
    send(8'h1E, 1'b1);
`ifdef VEC_PACK_ZERO_PAD_EN
    checks++;
    if (m_valid !== 1'b1 || pk() !== 32'h00001ECE) begin failures++;
      $display("FAIL short_vec got=%b/%h exp=1/00001ece", m_valid, pk()); end
    checks++;
    if (m_count !== 3'd2 || m_last !== 1'b1 || err_short !== 1'b0) begin
      failures++;
      $display("FAIL short_meta got=%0d/%b/%b exp=2/1/0",
               m_count, m_last, err_short); end
    tick();
`else
    checks++;
    if (m_valid !== 1'b0 || pk() !== 32'h0 || err_short !== 1'b1) begin
      failures++;
      $display("FAIL short_drop got=%b/%h/%b exp=0/0/1",
               m_valid, pk(), err_short); end
    tick();
    checks++;
    if (err_short !== 1'b0 || m_valid !== 1'b0) begin failures++;
      $display("FAIL short_pulse got=%b/%b exp=0/0", err_short, m_valid); end
`endif
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || pk() !== 32'h04030201) begin failures++;
      $display("FAIL short_after got=%b/%h exp=1/04030201", m_valid, pk()); end
    tick();
  endtask

  task automatic test_ena();
    m_ready = 1'b1;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    ena = 1'b0; s_valid = 1'b1; s_data = 8'd99;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0) begin failures++;
        $display("FAIL ena_ready[%0d] got=%b exp=0", c, s_ready); end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || pk() !== 32'h00000201) begin failures++;
      $display("FAIL ena_hold got=%b/%h exp=0/00000201", m_valid, pk()); end
    ena = 1'b1;
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || pk() !== 32'h04030201 || m_last !== 1'b1) begin
      failures++;
      $display("FAIL ena_resume got=%b/%h/%b exp=1/04030201/1",
               m_valid, pk(), m_last); end
    tick();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    send(8'd5, 1'b0);
    send(8'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pk() !== 32'h0 || m_valid !== 1'b0 || err_short !== 1'b0) begin
      failures++;
      $display("FAIL arst_clear got=%h/%b/%b exp=0/0/0",
               pk(), m_valid, err_short); end
    #2;
    rst_n = 1'b1;
    tick();
    send(8'd7, 1'b0);
    send(8'd8, 1'b0);
    send(8'd9, 1'b0);
    send(8'd10, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || pk() !== 32'h0A090807 || m_count !== 3'd4) begin
      failures++;
      $display("FAIL arst_clean got=%b/%h/%0d exp=1/0a090807/4",
               m_valid, pk(), m_count); end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_vector();
    test_back_to_back();
    test_backpressure();
    test_short_frame();
    test_ena();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
